// File: rtl/echo_delay_pkg.sv
// Shared FSM encoding and saturation limits for the echo/delay controller.
// Limits are derived from the sample width, so each user passes its own width.
package echo_delay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        MIX,
        OUT,
        CLEAR
    } state_t;

    // Largest positive two's-complement value at width w
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative two's-complement value at width w
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/echo_delay_ctrl_mix.sv
// Combinational feedback mixer: y = sat(x + floor(d * gain / 2**GAIN_WIDTH)).
// Kept on its own so the arithmetic can be exercised without the FSM around it.
module echo_mix
    import echo_delay_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] d,
    input  logic        [GAIN_WIDTH-1:0] gain,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic signed [PW-1:0] LIM_MAX = PW'(sat_max(DATA_WIDTH));
    localparam logic signed [PW-1:0] LIM_MIN = PW'(sat_min(DATA_WIDTH));

    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic signed [PW-1:0] sum;

    // The sum is held at the full product width; it is numerically identical
    // to a DATA_WIDTH+1 sum since |shifted| never exceeds |d|.
    always_comb begin
        d_ext   = {{(GAIN_WIDTH + 1){d[DATA_WIDTH-1]}}, d};
        x_ext   = {{(GAIN_WIDTH + 1){x[DATA_WIDTH-1]}}, x};
        g_ext   = {{(DATA_WIDTH + 1){1'b0}}, gain};
        prod    = d_ext * g_ext;
        prod_sh = prod >>> GAIN_WIDTH;
        sum     = x_ext + prod_sh;
        if (sum > LIM_MAX) begin
            y = LIM_MAX[DATA_WIDTH-1:0];
        end else if (sum < LIM_MIN) begin
            y = LIM_MIN[DATA_WIDTH-1:0];
        end else begin
            y = sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/echo_delay_ctrl.sv
// Feedback echo/delay controller driving an external 1-cycle-latency BRAM.
// Optional ECHO_DELAY_CLEAR_EN zero-fills the delay line after reset release.
module echo_delay_ctrl
    import echo_delay_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 10,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_in_valid,
    output logic                         sample_in_ready,
    input  logic        [ADDR_WIDTH-1:0] delay_len,
    input  logic        [GAIN_WIDTH-1:0] gain,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_out_valid,
    input  logic                         sample_out_ready,
    output logic        [ADDR_WIDTH-1:0] bram_read_addr,
    output logic        [ADDR_WIDTH-1:0] bram_write_addr,
    output logic signed [DATA_WIDTH-1:0] bram_data_in,
    output logic                         bram_wr_en,
    input  logic signed [DATA_WIDTH-1:0] bram_data_out
);

`ifdef ECHO_DELAY_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    logic [ADDR_WIDTH-1:0] clr_addr_reg;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
    logic signed [DATA_WIDTH-1:0] x_reg;
    logic signed [DATA_WIDTH-1:0] d_reg;
    logic [GAIN_WIDTH-1:0]   gain_reg;
    logic signed [DATA_WIDTH-1:0] mix_y;

    echo_mix #(
        .DATA_WIDTH(DATA_WIDTH),
        .GAIN_WIDTH(GAIN_WIDTH)
    ) u_mix (
        .x   (x_reg),
        .d   (d_reg),
        .gain(gain_reg),
        .y   (mix_y)
    );

    // Ready is registered so it stays low during reset and rises one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= RESET_STATE;
            wr_ptr_reg       <= '0;
            x_reg            <= '0;
            d_reg            <= '0;
            gain_reg         <= '0;
            sample_in_ready  <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            bram_read_addr   <= '0;
            bram_write_addr  <= '0;
            bram_data_in     <= '0;
            bram_wr_en       <= 1'b0;
`ifdef ECHO_DELAY_CLEAR_EN
            clr_addr_reg     <= '0;
`endif
        end else begin
            bram_wr_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sample_in_ready && sample_in_valid) begin
                        x_reg           <= sample_in;
                        gain_reg        <= gain;
                        bram_read_addr  <= wr_ptr_reg - delay_len;
                        sample_in_ready <= 1'b0;
                        state_reg       <= READ;
                    end else begin
                        sample_in_ready <= 1'b1;
                    end
                end
                READ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    d_reg     <= bram_data_out;
                    state_reg <= MIX;
                end
                MIX: begin
                    sample_out       <= mix_y;
                    sample_out_valid <= 1'b1;
                    bram_write_addr  <= wr_ptr_reg;
                    bram_data_in     <= mix_y;
                    bram_wr_en       <= 1'b1;
                    wr_ptr_reg       <= wr_ptr_reg + 1'b1;
                    state_reg        <= OUT;
                end
                OUT: begin
                    if (sample_out_ready) begin
                        sample_out_valid <= 1'b0;
                        sample_in_ready  <= 1'b1;
                        state_reg        <= IDLE;
                    end
                end
`ifdef ECHO_DELAY_CLEAR_EN
                CLEAR: begin
                    bram_write_addr <= clr_addr_reg;
                    bram_data_in    <= '0;
                    bram_wr_en      <= 1'b1;
                    clr_addr_reg    <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == {ADDR_WIDTH{1'b1}}) begin
                        sample_in_ready <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
`endif
                default: begin
                    sample_in_ready <= 1'b0;
                    state_reg       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl with a behavioural 16-entry BRAM.
// Works with or without ECHO_DELAY_CLEAR_EN defined.
module tb_echo_delay_ctrl;

    logic        clk;
    logic        rstn;
    logic [23:0] sample_in;
    logic        sample_in_valid;
    logic        sample_in_ready;
    logic [3:0]  delay_len;
    logic [7:0]  gain;
    logic [23:0] sample_out;
    logic        sample_out_valid;
    logic        sample_out_ready;
    logic [3:0]  bram_read_addr;
    logic [3:0]  bram_write_addr;
    logic [23:0] bram_data_in;
    logic        bram_wr_en;
    logic [23:0] bram_data_out;

    logic        mem_clr;
    logic [23:0] mem [16];
    logic [3:0]  rd_q;
    logic [3:0]  waddr_q [$];
    logic [23:0] wdata_q [$];

    int n_total = 0;
    int n_bad   = 0;

    echo_delay_ctrl #(
        .DATA_WIDTH(24),
        .ADDR_WIDTH(4),
        .GAIN_WIDTH(8)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .sample_in_ready (sample_in_ready),
        .delay_len       (delay_len),
        .gain            (gain),
        .sample_out      (sample_out),
        .sample_out_valid(sample_out_valid),
        .sample_out_ready(sample_out_ready),
        .bram_read_addr  (bram_read_addr),
        .bram_write_addr (bram_write_addr),
        .bram_data_in    (bram_data_in),
        .bram_wr_en      (bram_wr_en),
        .bram_data_out   (bram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read address, write on the edge after wr_en is seen
    always @(posedge clk) begin
        rd_q <= bram_read_addr;
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bram_wr_en) begin
            mem[bram_write_addr] <= bram_data_in;
        end
        if (bram_wr_en) begin
            waddr_q.push_back(bram_write_addr);
            wdata_q.push_back(bram_data_in);
        end
    end
    assign bram_data_out = mem[rd_q];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (sample_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_wait", 32'(sample_in_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        rstn    = 1'b1;
        wait_ready();
        @(negedge clk);
    endtask

    task automatic send(input logic [23:0] x, input logic [3:0] dl, input logic [7:0] g,
                        input int hold, output logic [23:0] y);
        int n;
        int lat;
        int n0;
        @(negedge clk);
        sample_in       = x;
        delay_len       = dl;
        gain            = g;
        sample_in_valid = 1'b1;
        if (hold > 0) sample_out_ready = 1'b0;
        n = 0;
        while (sample_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sample_in_ready !== 1'b1) check_val("accept_timeout", 32'(sample_in_ready), 32'd1);
        n0 = waddr_q.size();
        @(negedge clk);
        // Scramble the inputs: the block must use what it latched at accept.
        sample_in_valid = 1'b0;
        sample_in       = ~x;
        delay_len       = ~dl;
        gain            = ~g;
        lat = 1;
        while (sample_out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        y = sample_out;
        check_val("latency", 32'(lat), 32'd4);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_val("bp_out_stable", 32'(sample_out), 32'(y));
                check_val("bp_valid_high", 32'(sample_out_valid), 32'd1);
                check_val("bp_ready_low", 32'(sample_in_ready), 32'd0);
            end
            check_val("bp_wr_pulses", 32'(waddr_q.size() - n0), 32'd1);
            sample_out_ready = 1'b1;
            @(negedge clk);
            check_val("bp_valid_drop", 32'(sample_out_valid), 32'd0);
        end
        $display("tx x=%06h dl=%0d g=%0d -> y=%06h lat=%0d", x, dl, g, y, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] y;
        int imp_in [7]  = '{1000, 0, 0, 0, 0, 0, 0};
        int imp_exp [7] = '{1000, 0, 0, 500, 0, 0, 250};
        int nq;

        rstn             = 1'b0;
        mem_clr          = 1'b0;
        sample_in        = '0;
        sample_in_valid  = 1'b0;
        delay_len        = '0;
        gain             = '0;
        sample_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(sample_in_ready), 32'd0);
        check_val("rst_out", 32'(sample_out), 32'd0);
        check_val("rst_out_valid", 32'(sample_out_valid), 32'd0);
        check_val("rst_raddr", 32'(bram_read_addr), 32'd0);
        check_val("rst_waddr", 32'(bram_write_addr), 32'd0);
        check_val("rst_wdata", 32'(bram_data_in), 32'd0);
        check_val("rst_wr_en", 32'(bram_wr_en), 32'd0);
        mem_clr = 1'b0;
        rstn    = 1'b1;
        nq      = waddr_q.size();
`ifdef ECHO_DELAY_CLEAR_EN
        wait_ready();
        @(negedge clk);
        check_val("clr_count", 32'(waddr_q.size() - nq), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (nq + i < waddr_q.size()) begin
                check_val($sformatf("clr_addr%0d", i), 32'(waddr_q[nq + i]), 32'(i));
                check_val($sformatf("clr_data%0d", i), 32'(wdata_q[nq + i]), 32'd0);
            end
        end
`else
        @(negedge clk);
        check_val("ready_after_rst", 32'(sample_in_ready), 32'd1);
        check_val("no_wr_after_rst", 32'(waddr_q.size() - nq), 32'd0);
`endif

        // Impulse through a 3-sample delay at half gain
        for (int i = 0; i < 7; i++) begin
            send(24'(imp_in[i]), 4'd3, 8'd128, 0, y);
            check_val($sformatf("impulse%0d", i), 32'(y), 32'(imp_exp[i]));
        end

        // Positive saturation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(24'h7FFFFF, 4'd1, 8'd255, 0, y);
            check_val($sformatf("sat_pos%0d", i), 32'(y), 32'h7FFFFF);
        end
        // Negative saturation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(24'h800000, 4'd1, 8'd255, 0, y);
            check_val($sformatf("sat_neg%0d", i), 32'(y), 32'h800000);
        end

        // Backpressure: gain 0 makes the output equal the input
        send(24'd5000, 4'd1, 8'd0, 6, y);
        check_val("bp_value", 32'(y), 32'd5000);

        // Full-depth delay with wrap of the write pointer
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(24'd400, 4'd0, 8'd64, 0, y);
            check_val($sformatf("wrap_out%0d", i), 32'(y), (i < 16) ? 32'd400 : 32'd500);
        end
        repeat (2) @(negedge clk);
        nq = waddr_q.size();
        for (int i = 0; i < 20; i++) begin
            check_val($sformatf("wrap_waddr%0d", i), 32'(waddr_q[nq - 20 + i]), 32'(i % 16));
        end

        // Reset asserted while in WAIT
        @(negedge clk);
        sample_in       = 24'd1234;
        delay_len       = 4'd2;
        gain            = 8'd100;
        sample_in_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        sample_in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        nq   = waddr_q.size();
        repeat (4) @(negedge clk);
        check_val("midrst_no_wr", 32'(waddr_q.size() - nq), 32'd0);
        check_val("midrst_valid", 32'(sample_out_valid), 32'd0);
        check_val("midrst_wr_en", 32'(bram_wr_en), 32'd0);
        rstn = 1'b1;
        wait_ready();
        send(24'd777, 4'd1, 8'd0, 0, y);
        check_val("midrst_out", 32'(y), 32'd777);
        repeat (2) @(negedge clk);
        check_val("midrst_waddr", 32'(waddr_q[waddr_q.size() - 1]), 32'd0);
        check_val("midrst_wdata", 32'(wdata_q[wdata_q.size() - 1]), 32'd777);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/echo_delay_ctrl.md
Name: echo_delay_ctrl

Overview:
Feedback echo/delay controller for the audio path. It accepts one signed sample per handshake and reads the sample from delay_len slots earlier out of the external simple-dual-port BRAM. That BRAM has 1-cycle read latency via a registered read address. The block mixes the delayed sample with the input under a fractional feedback gain, writes the result back at the circular write pointer, and emits it downstream. It sits between the synth/mixer output and the DAC/I2S serializer, and drives the BRAM ports directly.

Parameters:
DATA_WIDTH, 24, sample width, signed two's complement.
ADDR_WIDTH, 10, BRAM address width; delay line depth = 2**ADDR_WIDTH.
GAIN_WIDTH, 8, unsigned feedback gain width; gain value = gain / 2**GAIN_WIDTH.

Ports:
clk  in  1  system clock, all logic on rising edge.
rstn  in  1  asynchronous active-low reset.
sample_in  in  DATA_WIDTH  input sample.
sample_in_valid  in  1  upstream valid.
sample_in_ready  out  1  block can accept.
delay_len  in  ADDR_WIDTH  delay in samples; sampled at accept; 0 means 2**ADDR_WIDTH.
gain  in  GAIN_WIDTH  feedback gain; sampled at accept.
sample_out  out  DATA_WIDTH  mixed output sample.
sample_out_valid  out  1  downstream valid.
sample_out_ready  in  1  downstream ready.
bram_read_addr  out  ADDR_WIDTH  to BRAM read_addr (registered).
bram_write_addr  out  ADDR_WIDTH  to BRAM write_addr (registered).
bram_data_in  out  DATA_WIDTH  to BRAM data_in (registered).
bram_wr_en  out  1  to BRAM wr_en, single-cycle pulse.
bram_data_out  in  DATA_WIDTH  from BRAM data_out.

Behaviour:
- Reset (async, rstn=0): state IDLE, wr_ptr=0. sample_out=0, sample_out_valid=0, bram_read_addr=0, bram_write_addr=0, bram_data_in=0, bram_wr_en=0. sample_in_ready=0 while rstn=0.
- FSM states: IDLE, READ, WAIT, MIX, OUT. sample_in_ready=1 only in IDLE.
- IDLE: on sample_in_valid, latch sample_in, gain, delay_len. Register bram_read_addr <= (wr_ptr - delay_len) mod 2**ADDR_WIDTH. Go to READ.
- READ: BRAM captures the read address at the end of this cycle. Go to WAIT.
- WAIT: bram_data_out is valid; latch it as d. Go to MIX.
- MIX: prod = d * gain, signed x unsigned, full width DATA_WIDTH+GAIN_WIDTH+1. Shift prod right arithmetically by GAIN_WIDTH (truncate toward -inf). sum = x + shifted, computed at DATA_WIDTH+1. Saturate sum to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] to give y. Register sample_out=y and sample_out_valid=1. Register bram_write_addr=wr_ptr, bram_data_in=y, bram_wr_en=1 (BRAM write occurs next edge). Increment wr_ptr, wrapping mod 2**ADDR_WIDTH. Go to OUT.
- OUT: bram_wr_en=0. Hold sample_out and sample_out_valid stable until sample_out_ready=1. On that edge drop valid and go to IDLE.
- Latency: accept edge to sample_out_valid=1 is 4 cycles. Maximum throughput is 1 sample per 5 cycles.
- Read/write to the same address never coincide. The read in READ precedes the write of the same sample. delay_len=0 reads the slot at wr_ptr before it is overwritten, giving a full 2**ADDR_WIDTH delay.
- delay_len or gain changing mid-operation has no effect until the next accept.
- Reset mid-operation aborts immediately. There are no partial writes: wr_en is only ever registered in MIX, and reset clears it.

Optional Feature:
- Macro ECHO_DELAY_CLEAR_EN.
- Defined: after reset release, the block enters CLEAR before IDLE. CLEAR writes 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle (bram_wr_en=1), with sample_in_ready=0 throughout. IDLE is entered the cycle after the last write.
- Undefined: reset goes straight to IDLE, and BRAM contents are whatever the configuration initialised them to.

Decomposition:
- Package echo_delay_pkg holds the FSM state encoding (IDLE, READ, WAIT, MIX, OUT, CLEAR) and the saturation-limit constants derived from DATA_WIDTH.
- One combinational sub-module, echo_mix: inputs x, d, gain; output y. It does the multiply, shift and saturate, and is unit-testable on its own.

Test Plan:
Common setup: ADDR_WIDTH=4, DATA_WIDTH=24, GAIN_WIDTH=8, bench models the BRAM, sample_out_ready=1 unless stated.
- Reset: rstn low 3 cycles, then high -> all outputs 0, sample_in_ready=1 next cycle. With the macro defined: 16 writes of 0 to addresses 0..15, then ready=1.
- Impulse: delay_len=3, gain=128, inputs 1000,0,0,0,0,0,0 -> outputs 1000,0,0,500,0,0,250. sample_out_valid rises exactly 4 cycles after each accept.
- Saturation: delay_len=1, gain=255, input 0x7FFFFF repeated -> second and later outputs 0x7FFFFF. Input 0x800000 repeated -> later outputs 0x800000.
- Backpressure: sample_out_ready=0 for 6 cycles in OUT -> sample_out stable, sample_in_ready=0, exactly one bram_wr_en pulse for that sample.
- Wrap: delay_len=0, gain=64, 20 samples of 400 -> outputs 0..15 are 400, outputs 16..19 are 500. bram_write_addr wraps 15->0.
- Reset mid-operation: rstn asserted in WAIT -> bram_wr_en never pulses. The next accepted sample writes to address 0.
